// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the fetch and memory-stage ports.
// One bus transaction in flight at a time; data wins unless the streak cap hits.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                F_stall,
  output logic                M_stall,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int SW =
    (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  localparam bit CAPPED = (MAX_D_STREAK != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic          sel_d;
  logic          grant, grant_d;
  logic          accept, complete;
  logic          i_elig, d_elig;

  // A port in its done cycle still has req high but is already served
  assign i_elig  = i_req & ~i_done;
  assign d_elig  = d_req & ~d_done;
  assign F_stall = i_req & ~i_done;
  assign M_stall = d_req & ~d_done;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    grant     = 1'b0;
    grant_d   = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_elig || d_elig) begin
          grant    = 1'b1;
          grant_d  = d_elig &
                     ~(i_elig & CAPPED & (streak == SMAX));
          state_nx = REQ;
          if (grant_d && i_req)
            streak_nx = (streak == SMAX) ?
                        streak : streak + SW'(1);
          else
            streak_nx = '0;
        end
      end
      REQ: begin
        if (mem_ready) begin
          accept = 1'b1;
          if (mem_rsp_valid) begin
            complete = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = RSP;
          end
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      sel_d     <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant) begin
        sel_d     <= grant_d;
        mem_valid <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_be    <= grant_d ? d_be : '1;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
      end
      if (accept)
        mem_valid <= 1'b0;
      if (complete) begin
        if (sel_d) begin
          d_done <= 1'b1;
          if (!mem_we)
            d_rdata <= mem_rdata;
        end else begin
          i_done  <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
